layer_scroll_ctrl: RTL and testbench

LAYER_SCROLL_CTRL -- requirements
Module: layer_scroll_ctrl

---
 rtl/layer_scroll_ctrl_if.sv | 34 +++
 rtl/layer_scroll_ctrl.sv | 104 ++++++++++
 tb/tb_layer_scroll_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_scroll_ctrl_if.sv
// ============================================================================
// Module      : layer_scroll_ctrl_if
// Description : Request/pulse bundle between the game controller and
//               layer_scroll_ctrl, which drives the layer row generator.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface layer_scroll_ctrl_if;
    logic       module_en;
    logic       one_ms_tick;
    logic       init_req;
    logic       scroll_req;
    logic       load;
    logic       start;
    logic [0:6] layer_map;
    logic [0:6] block_type;
    logic       busy;
    logic       scroll_done;
    logic [7:0] scroll_count;

    modport master (
        output module_en, one_ms_tick, init_req, scroll_req,
        input  load, start, layer_map, block_type, busy, scroll_done, scroll_count
    );

    modport slave (
        input  module_en, one_ms_tick, init_req, scroll_req,
        output load, start, layer_map, block_type, busy, scroll_done, scroll_count
    );
endinterface

`default_nettype wire

// File: rtl/layer_scroll_ctrl.sv
// ============================================================================
// Module      : layer_scroll_ctrl
// Description : Generates pseudo-random layer rows and sequences load/scroll
//               pulses to the layers, pacing scrolls by one_ms_tick.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module layer_scroll_ctrl #(
    parameter int unsigned SCROLL_MS = 150,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input wire logic        clk,
    input wire logic        rst,
    layer_scroll_ctrl_if.slave ctrl
);

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [15:0] c_SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [7:0]  c_LAST_TICK = 8'(SCROLL_MS - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_GEN    = 3'd1;
    localparam logic [2:0] c_LOAD   = 3'd2;
    localparam logic [2:0] c_START  = 3'd3;
    localparam logic [2:0] c_SCROLL = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic        r_mode_init;
    logic [15:0] r_lfsr;
    logic        w_feedback;
    logic [7:0]  r_ticks;
    logic [7:0]  r_count;
    logic [0:6]  r_map;
    logic [0:6]  r_type;
    logic [0:6]  w_gen_map;
    logic [0:6]  w_gen_type;

    assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (ctrl.module_en && (ctrl.init_req || ctrl.scroll_req)) w_next = c_GEN;
            c_GEN:    w_next = r_mode_init ? c_LOAD : c_START;
            c_LOAD:   w_next = c_IDLE;
            c_START:  w_next = c_SCROLL;
            c_SCROLL: if (ctrl.one_ms_tick && (r_ticks == c_LAST_TICK)) w_next = c_DONE;
            c_DONE:   w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    // An empty row is never emitted; column 3 is forced instead.
    always_comb begin
        w_gen_map  = '0;
        w_gen_type = '0;
        for (int i = 0; i < 7; i++) begin
            w_gen_map[i]  = r_lfsr[i];
            w_gen_type[i] = r_lfsr[8 + i];
        end
        if (r_lfsr[6:0] == 7'd0) w_gen_map = 7'b0001000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_mode_init <= 1'b0;
            r_lfsr      <= c_SEED;
            r_ticks     <= 8'd0;
            r_count     <= 8'd0;
            r_map       <= '0;
            r_type      <= '0;
        end else begin
            r_state <= w_next;
            if (ctrl.module_en) r_lfsr <= {r_lfsr[14:0], w_feedback};
            if (r_state == c_IDLE) r_mode_init <= ctrl.init_req;
            case (r_state)
                c_GEN: begin
                    r_map  <= w_gen_map;
                    r_type <= w_gen_type;
                end
                c_START:  r_ticks <= 8'd0;
                c_SCROLL: if (ctrl.one_ms_tick) r_ticks <= r_ticks + 8'd1;
                c_DONE:   if (r_count != 8'hFF) r_count <= r_count + 8'd1;
                default: ;
            endcase
        end
    end

    assign ctrl.load         = (r_state == c_LOAD);
    assign ctrl.start        = (r_state == c_START);
    assign ctrl.scroll_done  = (r_state == c_DONE);
    assign ctrl.busy         = (r_state != c_IDLE);
    assign ctrl.layer_map    = r_map;
    assign ctrl.block_type   = r_type;
    assign ctrl.scroll_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_layer_scroll_ctrl.sv
// ============================================================================
// Module      : tb_layer_scroll_ctrl
// Description : Self-checking bench for layer_scroll_ctrl with a timestamp
//               based transaction model and directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_layer_scroll_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    layer_scroll_ctrl_if ifa ();
    layer_scroll_ctrl_if ifb ();

    layer_scroll_ctrl #(.SCROLL_MS(150), .LFSR_SEED(16'hACE1)) u_dut_a (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ifa.slave)
    );

    layer_scroll_ctrl #(.SCROLL_MS(1), .LFSR_SEED(16'h0080)) u_dut_b (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ifb.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int dones_a  = 0;
    int dones_b  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: each transaction is described by the cycle of its row generation
    // (m_g) and the cycle of its completion (m_end); outputs follow from those.
    int          m_cyc = 0;
    bit          m_act  [2];
    bit          m_init [2];
    int          m_g    [2];
    int          m_end  [2];
    int          m_tk   [2];
    int          m_cnt  [2];
    logic [15:0] m_lfsr [2];
    logic [0:6]  m_map  [2];
    logic [0:6]  m_typ  [2];

    function automatic int scroll_ms(input int k);
        return (k == 0) ? 150 : 1;
    endfunction

    task automatic model_step(input int k, input int cyc, input logic r, input logic en,
                              input logic tk, input logic ir, input logic sr);
        int c;
        c = cyc + 1;
        if (r) begin
            m_act[k]  = 0;
            m_init[k] = 0;
            m_g[k]    = -10;
            m_end[k]  = -10;
            m_tk[k]   = 0;
            m_cnt[k]  = 0;
            m_lfsr[k] = (k == 0) ? 16'hACE1 : 16'h0080;
            m_map[k]  = '0;
            m_typ[k]  = '0;
            return;
        end
        if (!m_act[k]) begin
            if (en && (ir || sr)) begin
                m_act[k]  = 1;
                m_init[k] = ir;
                m_g[k]    = c;
                m_end[k]  = ir ? c + 1 : -1;
                m_tk[k]   = 0;
            end
        end else begin
            if (cyc == m_g[k]) begin
                for (int i = 0; i < 7; i++) begin
                    m_map[k][i] = m_lfsr[k][i];
                    m_typ[k][i] = m_lfsr[k][8 + i];
                end
                if (m_lfsr[k][6:0] == 7'd0) m_map[k] = 7'b0001000;
            end
            if (!m_init[k] && m_end[k] < 0 && cyc > m_g[k] + 1 && tk) begin
                m_tk[k]++;
                if (m_tk[k] == scroll_ms(k)) m_end[k] = c;
            end
            if (cyc == m_end[k]) begin
                m_act[k] = 0;
                if (!m_init[k] && m_cnt[k] < 255) m_cnt[k]++;
            end
        end
        if (en) m_lfsr[k] = {m_lfsr[k][14:0], m_lfsr[k][15] ^ m_lfsr[k][13] ^ m_lfsr[k][12] ^ m_lfsr[k][10]};
    endtask

    function automatic logic [25:0] model_out(input int k);
        logic first;
        first = m_act[k] && (m_cyc == m_g[k] + 1);
        return {m_act[k], first && m_init[k], first && !m_init[k],
                m_act[k] && !m_init[k] && (m_cyc == m_end[k]),
                m_map[k], m_typ[k], 8'(m_cnt[k])};
    endfunction

    always @(posedge clk) begin
        model_step(0, m_cyc, rst, ifa.module_en, ifa.one_ms_tick, ifa.init_req, ifa.scroll_req);
        model_step(1, m_cyc, rst, ifb.module_en, ifb.one_ms_tick, ifb.init_req, ifb.scroll_req);
        m_cyc++;
        #1;
        check("dut_a_outputs", 32'({ifa.busy, ifa.load, ifa.start, ifa.scroll_done,
              ifa.layer_map, ifa.block_type, ifa.scroll_count}), 32'(model_out(0)));
        check("dut_b_outputs", 32'({ifb.busy, ifb.load, ifb.start, ifb.scroll_done,
              ifb.layer_map, ifb.block_type, ifb.scroll_count}), 32'(model_out(1)));
        if (ifa.scroll_done === 1'b1) dones_a++;
        if (ifb.scroll_done === 1'b1) dones_b++;
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One tick on dut A, 20 clocks after the previous one.
    task automatic send_ticks(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            nclk(19);
            ifa.one_ms_tick = 1'b1;
            nclk(1);
            ifa.one_ms_tick = 1'b0;
        end
    endtask

    function automatic logic [25:0] outs_a();
        return {ifa.busy, ifa.load, ifa.start, ifa.scroll_done,
                ifa.layer_map, ifa.block_type, ifa.scroll_count};
    endfunction

    initial begin
        int base;
        ifa.module_en = 0; ifa.one_ms_tick = 0; ifa.init_req = 0; ifa.scroll_req = 0;
        ifb.module_en = 0; ifb.one_ms_tick = 0; ifb.init_req = 0; ifb.scroll_req = 0;
        nclk(3);
        rst = 1'b0;
        nclk(10);
        check("idle_outputs_zero", 32'(outs_a()), 32'd0);

        // Init: first GEN sees one LFSR step past ACE1, i.e. 16'h59C3.
        ifa.module_en = 1; ifa.init_req = 1;
        nclk(1);
        ifa.init_req = 0;
        check("init_gen_busy_noload", {30'd0, ifa.busy, ifa.load}, 32'b10);
        nclk(1);
        check("init_load_pulse", {29'd0, ifa.busy, ifa.load, ifa.start}, 32'b110);
        check("init_layer_map", 32'(ifa.layer_map), 32'(7'b1100001));
        check("init_block_type", 32'(ifa.block_type), 32'(7'b1001101));
        nclk(1);
        check("init_back_idle", {30'd0, ifa.busy, ifa.load}, 32'd0);

        // Scroll with a tick in START that must not count.
        nclk(3);
        ifa.scroll_req = 1;
        nclk(1);
        ifa.scroll_req = 0;
        nclk(1);
        check("scroll_start_pulse", {30'd0, ifa.start, ifa.load}, 32'b10);
        ifa.one_ms_tick = 1;
        nclk(1);
        ifa.one_ms_tick = 0;
        send_ticks(149);
        check("scroll_not_done_149", {30'd0, ifa.busy, ifa.scroll_done}, 32'b10);
        send_ticks(1);
        check("scroll_done_150", 32'(ifa.scroll_done), 32'd1);
        nclk(1);
        check("scroll_count_1", 32'(ifa.scroll_count), 32'd1);

        // Both requests together: init wins.
        nclk(2);
        ifa.init_req = 1; ifa.scroll_req = 1;
        nclk(1);
        ifa.init_req = 0; ifa.scroll_req = 0;
        nclk(1);
        check("both_req_init_path", {30'd0, ifa.load, ifa.start}, 32'b10);
        nclk(2);

        // Held scroll_req: three back-to-back scrolls.
        base = dones_a;
        ifa.scroll_req = 1;
        for (int i = 0; i < 12000 && dones_a < base + 3; i++) begin
            ifa.one_ms_tick = (i % 20 == 19);
            @(negedge clk);
            if (ifa.start && dones_a >= base + 2) ifa.scroll_req = 0;
        end
        ifa.one_ms_tick = 0;
        ifa.scroll_req = 0;
        check("held_scroll_dones", 32'(dones_a), 32'(base + 3));
        nclk(5);
        check("held_scroll_count", {23'd0, ifa.busy, ifa.scroll_count}, 32'd4);

        // Reset on the 75th tick aborts the scroll silently.
        ifa.scroll_req = 1;
        nclk(1);
        ifa.scroll_req = 0;
        nclk(1);
        send_ticks(74);
        base = dones_a;
        nclk(19);
        ifa.one_ms_tick = 1;
        rst = 1;
        nclk(1);
        ifa.one_ms_tick = 0;
        rst = 0;
        check("abort_outputs_reset", 32'(outs_a()), 32'd0);
        nclk(3);
        check("abort_no_done", 32'(dones_a), 32'(base));
        ifa.scroll_req = 1;
        nclk(1);
        ifa.scroll_req = 0;
        nclk(1);
        send_ticks(149);
        check("rescroll_not_done_149", 32'(ifa.scroll_done), 32'd0);
        send_ticks(1);
        check("rescroll_done_150", 32'(ifa.scroll_done), 32'd1);
        nclk(1);
        check("rescroll_count_1", 32'(ifa.scroll_count), 32'd1);

        // Seed 16'h0080 steps to 16'h0100: empty low bits force column 3.
        ifb.module_en = 1; ifb.init_req = 1;
        nclk(1);
        ifb.init_req = 0;
        nclk(1);
        check("zero_row_load", 32'(ifb.load), 32'd1);
        check("zero_row_map", 32'(ifb.layer_map), 32'(7'b0001000));
        check("zero_row_type", 32'(ifb.block_type), 32'(7'b1000000));
        nclk(2);

        // Saturation of scroll_count.
        ifb.one_ms_tick = 1; ifb.scroll_req = 1;
        for (int i = 0; i < 2000 && dones_b < 260; i++) @(negedge clk);
        ifb.scroll_req = 0;
        nclk(6);
        ifb.one_ms_tick = 0;
        check("sat_dones", 32'(dones_b), 32'd260);
        check("sat_count_255", 32'(ifb.scroll_count), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
